rr_mux_reg: RTL
===============

# rr_mux_reg

Parametrised N-input, WIDTH-bit arbitrating multiplexer with a registered, valid/ready-handshaked output stage. It is the sequential successor to the plain combinational select muxes. It merges several producer channels onto one consumer, for example multiple requesters onto a shared memory or writeback port in the pipelined datapath. The merge uses either round-robin or fixed-priority arbitration, with one cycle of latency and full throughput.

## Interface
- WIDTH, 64, data bits per channel
- N, 4, number of input channels; power of two, N >= 2
- SELW, $clog2(N), width of channel index (derived, not overridden)

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- rr_en  input  1  1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
- in_valid  input  N  per-channel request; bit i belongs to channel i
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  N  one-hot or zero; channel i's word is accepted this cycle when in_valid[i] & in_ready[i]
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered selected word
- out_sel  output  SELW  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts the word when out_valid & out_ready

## Operation
- **Single output register.**
  - load = ~out_valid | out_ready.
  - The register is loaded whenever it is empty or is being drained in the same cycle.
- **Grant (combinational from in_valid, rr_en, ptr).**
  - rr_en=0: grant the lowest index i with in_valid[i]=1.
  - rr_en=1: grant the first i with in_valid[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N).
  - No valid input means no grant.
- **in_ready.** in_ready[i] = grant[i] & load. At most one bit is set. in_ready never depends on in_valid[j] for j ≠ granted index beyond arbitration.
- **On a clock edge with load=1:**
  - If a grant exists: out_valid←1, out_data←in_data[g], out_sel←g.
  - If no grant exists: out_valid←0. out_data and out_sel keep their previous values.
- **On a clock edge with load=0 (out_valid=1, out_ready=0):** out_valid, out_data and out_sel are held stable. No input is accepted.
- **Pointer ptr (SELW bits).**
  - On each accepted input with rr_en=1: ptr←(g+1) mod N. Index N-1 wraps to 0.
  - With rr_en=0, ptr is held and ignored.
  - Toggling rr_en takes effect on the grant in the same cycle.
- **Reset (asynchronous, any time, including mid-transfer).**
  - Outputs: out_valid=0, out_data=0, out_sel=0, in_ready=0 while reset_n=0.
  - State: ptr=0.
  - Any word in the output register is discarded.
- Producers may drop or change in_valid or in_data without having been accepted. The block keeps no lock state between cycles.

## Timing
- Latency: a word accepted at edge k appears on out_data/out_valid after edge k, visible in cycle k+1.
- Throughput: one word per cycle when out_ready is held at 1 and at least one in_valid is set.
- Backpressure: for every cycle that out_ready=0 while out_valid=1:
  - the output register is frozen;
  - all in_ready bits are 0.
- Simultaneous drain and fill (out_valid=1, out_ready=1, grant present): the old word leaves and the new word loads on the same edge, so out_valid stays 1.
- in_ready is combinational from out_valid, out_ready, in_valid, rr_en and ptr. There is no combinational path from in_data to any output.

## Test plan
Bench parameters: N=4, WIDTH=64.
- **Reset:** hold reset_n=0 with all inputs active. Require out_valid=0, out_data=0, out_sel=0 and in_ready=0. Release reset_n. In the first cycle, rr_en=1 and in_valid=4'b1111 must give in_ready=4'b0001 (ptr=0).
- **Round-robin fairness:** rr_en=1, in_valid=4'b1111, out_ready=1, in_data[i]=64'hA0+i. Require out_sel to sequence 0,1,2,3,0,1 on consecutive cycles, wrapping after index 3. out_data must track as 64'hA0, 64'hA1, …, and out_valid must stay continuously 1.
- **Fixed priority:** rr_en=0, in_valid=4'b1010 for 3 cycles. Require out_sel=1 each cycle and in_ready=4'b0010.
- **Sparse round-robin:** rr_en=1, ptr=2 (after a channel-1 grant), in_valid=4'b0011. Require a grant to channel 0 (search order 2,3,0), then ptr=1.
- **Backpressure:** load 64'hDEAD from channel 2, then hold out_ready=0 for 4 cycles. Require out_data=64'hDEAD, out_sel=2 and out_valid=1 to stay stable, with in_ready=0. Raise out_ready with channel 3 valid. Require an accept on the same edge and, next cycle, out_data=channel 3's data.
- **Idle drain and mid-operation reset:** drain with in_valid=0. Require out_valid to fall to 0 after the accepting edge. Then assert reset_n=0 asynchronously between edges while out_valid=1. Require out_valid=0 immediately, without waiting for the next edge.

Source files
------------

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-input arbitrating multiplexer with a registered
// valid/ready output stage. It supports round-robin or fixed-priority
// arbitration, has one cycle of latency, and sustains full throughput.
module rr_mux_reg #(
    parameter  int WIDTH = 64,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rr_en,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);

    logic [SELW-1:0]  ptr;
    logic             load;
    logic             gnt_any;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;

    // The output register may take a new word when it is empty or draining.
    assign load = ~out_valid | out_ready;

    // Search for the first valid channel. In round-robin mode the search
    // starts at ptr; in fixed-priority mode it starts at 0. N is a power of
    // two, so the SELW-bit addition wraps modulo N by itself.
    always_comb begin
        logic [SELW-1:0] idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = SELW'(k) + (rr_en ? ptr : '0);
            if (!gnt_any && in_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    // Select the granted word. It feeds only the register, so there is no
    // combinational path from in_data to any output.
    always_comb begin
        gnt_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
    end

    // Drive a one-hot ready to the granted channel only while the register
    // can load. Ready is forced low while reset is asserted.
    always_comb begin
        in_ready = '0;
        if (reset_n && load && gnt_any) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // Update the output register and the round-robin pointer on each accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (gnt_any) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_sel   <= gnt_idx;
                if (rr_en) begin
                    ptr <= gnt_idx + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
